// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Holds the fetch FSM encoding, the NOP filler word and the PC stride.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] PC_STEP = 32'd4;

  // Instruction addresses are always word aligned; low bits are dropped.
  function automatic logic [31:0] alignPc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch program counter: holds the next address to request.
// A redirect always wins over the sequential step; the sum wraps modulo 2^32.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        i_redirect,
  input  logic [31:0] i_redirectPc,
  input  logic        i_advance,
  input  logic [31:0] i_advanceBase,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;
  logic [31:0] w_stepPc;

  assign w_stepPc = i_advanceBase + PC_STEP;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_pc <= RESET_PC;
    end else if (i_redirect) begin
      r_pc <= alignPc(i_redirectPc);
    end else if (i_advance) begin
      r_pc <= w_stepPc;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one memory request at a time and
// presents each returned word to decode until it is accepted.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enbl_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  fetch_state_e r_state;
  fetch_state_e w_stateNext;
  fetch_state_e w_afterTxn;

  logic        r_kill;
  logic [31:0] r_issuedPc;
  logic [31:0] r_instr;
  logic [31:0] r_instrPc;
  logic [31:0] w_pc;
  logic        w_capture;

  fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pcReg (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .i_redirect   (redirect_i),
    .i_redirectPc (redirect_pc_i),
    .i_advance    (w_capture),
    .i_advanceBase(r_issuedPc),
    .o_pc         (w_pc)
  );

  // A response is kept only if nothing invalidated it while it was in flight.
  assign w_capture  = (r_state == WAIT) && imem_rvalid_i && !r_kill && !redirect_i;
  assign w_afterTxn = enbl_i ? REQ : IDLE;

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        if (enbl_i) begin
          w_stateNext = REQ;
        end
      end
      REQ: begin
        if (imem_gnt_i) begin
          w_stateNext = WAIT;
        end else if (!enbl_i) begin
          w_stateNext = IDLE;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          w_stateNext = w_capture ? HOLD : w_afterTxn;
        end
      end
      HOLD: begin
        if (redirect_i || instr_ready_i) begin
          w_stateNext = w_afterTxn;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_kill     <= 1'b0;
      r_issuedPc <= RESET_PC;
      r_instr    <= NOP;
      r_instrPc  <= 32'h0000_0000;
    end else begin
      r_state <= w_stateNext;
      if (r_state == REQ && imem_gnt_i) begin
        r_issuedPc <= w_pc;
        r_kill     <= redirect_i;
      end else if (r_state == WAIT) begin
        if (imem_rvalid_i) begin
          r_kill <= 1'b0;
        end else if (redirect_i) begin
          r_kill <= 1'b1;
        end
      end
      if (w_capture) begin
        r_instr   <= imem_rdata_i;
        r_instrPc <= r_issuedPc;
      end
    end
  end

  assign imem_req_o    = (r_state == REQ);
  assign imem_addr_o   = w_pc;
  assign instr_valid_o = (r_state == HOLD);
  assign instr_o       = r_instr;
  assign instr_pc_o    = r_instrPc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl with a response scoreboard.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic        clk_i;
  logic        rst_ni;
  logic        enbl_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  int passCount  = 0;
  int checkCount = 0;

  logic [31:0] sbAddr[$];
  logic [31:0] sbData[$];

  logic [31:0] heldInstr;
  logic [31:0] heldPc;

  fetch_ctrl #(
    .RESET_PC(RESET_PC)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .enbl_i       (enbl_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .instr_valid_o(instr_valid_o),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .instr_ready_i(instr_ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] dataFor(input logic [31:0] addr);
    return addr ^ 32'h5A5A_0000;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic checkResetOutputs();
    checkBit("rstReq", imem_req_o, 1'b0);
    checkVal("rstAddr", imem_addr_o, RESET_PC);
    checkBit("rstValid", instr_valid_o, 1'b0);
    checkVal("rstInstr", instr_o, NOP_WORD);
    checkVal("rstInstrPc", instr_pc_o, 32'h0000_0000);
  endtask

  task automatic waitReq();
    int n = 0;
    while (imem_req_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (imem_req_o !== 1'b1) checkBit("reqTimeout", imem_req_o, 1'b1);
  endtask

  task automatic applyStimulus(input logic [31:0] addr);
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = dataFor(addr);
    sbAddr.push_back(addr);
    sbData.push_back(dataFor(addr));
  endtask

  task automatic checkOutput(output logic [31:0] instrSeen, output logic [31:0] pcSeen);
    logic [31:0] expI;
    logic [31:0] expP;
    checkBit("holdValid", instr_valid_o, 1'b1);
    if (sbAddr.size() == 0) begin
      checkVal("sbUnderflow", 32'(sbAddr.size()), 32'd1);
    end else begin
      expI = sbData.pop_front();
      expP = sbAddr.pop_front();
      checkVal("instr", instr_o, expI);
      checkVal("instrPc", instr_pc_o, expP);
    end
    instrSeen = instr_o;
    pcSeen    = instr_pc_o;
  endtask

  task automatic doFetch(input logic [31:0] addr, input int stall);
    logic [31:0] hI;
    logic [31:0] hP;
    waitReq();
    checkVal("reqAddr", imem_addr_o, addr);
    applyStimulus(addr);
    instr_ready_i = (stall == 0);
    tick();
    imem_rvalid_i = 1'b0;
    checkOutput(hI, hP);
    for (int i = 0; i < stall; i++) begin
      tick();
      checkBit("stallValid", instr_valid_o, 1'b1);
      checkBit("stallNoReq", imem_req_o, 1'b0);
      checkVal("stallInstr", instr_o, hI);
      checkVal("stallPc", instr_pc_o, hP);
    end
    instr_ready_i = 1'b1;
  endtask

  initial begin
    rst_ni        = 1'b0;
    enbl_i        = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    instr_ready_i = 1'b1;
    tick();
    tick();
    checkResetOutputs();

    rst_ni = 1'b1;
    enbl_i = 1'b1;
    doFetch(32'h0000_0000, 0);
    doFetch(32'h0000_0004, 0);
    doFetch(32'h0000_0008, 0);
    doFetch(32'h0000_000C, 5);

    // Drop enable while requesting without a grant, then resume.
    waitReq();
    checkVal("preDisableAddr", imem_addr_o, 32'h0000_0010);
    enbl_i = 1'b0;
    tick();
    checkBit("disabledReq", imem_req_o, 1'b0);
    tick();
    tick();
    checkBit("idleReq", imem_req_o, 1'b0);
    enbl_i = 1'b1;
    doFetch(32'h0000_0010, 0);

    // Redirect in REQ to an unaligned top-of-memory target, then wrap.
    waitReq();
    checkVal("preRedirAddr", imem_addr_o, 32'h0000_0014);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFF;
    tick();
    redirect_i = 1'b0;
    checkBit("redirReq", imem_req_o, 1'b1);
    checkVal("redirAlign", imem_addr_o, 32'hFFFF_FFFC);
    doFetch(32'hFFFF_FFFC, 0);
    doFetch(32'h0000_0000, 0);

    // Redirect while holding, coincident with ready.
    waitReq();
    checkVal("holdRedirReqAddr", imem_addr_o, 32'h0000_0004);
    applyStimulus(32'h0000_0004);
    instr_ready_i = 1'b0;
    tick();
    imem_rvalid_i = 1'b0;
    checkOutput(heldInstr, heldPc);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    instr_ready_i = 1'b1;
    tick();
    redirect_i = 1'b0;
    checkBit("holdRedirValid", instr_valid_o, 1'b0);
    checkBit("holdRedirReq", imem_req_o, 1'b1);
    checkVal("holdRedirAddr", imem_addr_o, 32'h0000_0200);
    doFetch(32'h0000_0200, 0);

    // Reset while waiting, with the old response arriving afterwards.
    waitReq();
    checkVal("preRstAddr", imem_addr_o, 32'h0000_0204);
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    rst_ni     = 1'b0;
    tick();
    rst_ni = 1'b1;
    checkResetOutputs();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid_i = 1'b0;
    checkBit("lateValid", instr_valid_o, 1'b0);
    checkBit("lateReq", imem_req_o, 1'b1);
    checkVal("lateAddr", imem_addr_o, RESET_PC);
    tick();
    checkBit("lateValid2", instr_valid_o, 1'b0);
    checkVal("lateInstr", instr_o, NOP_WORD);
    doFetch(32'h0000_0000, 0);
    doFetch(32'h0000_0004, 0);

    // Redirect during WAIT of PC 8 kills its response.
    waitReq();
    checkVal("killReqAddr", imem_addr_o, 32'h0000_0008);
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i    = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    tick();
    redirect_i    = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = dataFor(32'h0000_0008);
    tick();
    imem_rvalid_i = 1'b0;
    checkBit("killValid", instr_valid_o, 1'b0);
    checkBit("killReq", imem_req_o, 1'b1);
    checkVal("killNextAddr", imem_addr_o, 32'h0000_0100);
    doFetch(32'h0000_0100, 0);

    checkVal("sbDrained", 32'(sbAddr.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the fetch address after reset.
REQ-002 clk_i  in  1  single clock, all state updates on rising edge.
REQ-003 rst_ni  in  1  reset, synchronous, active-low.
REQ-004 enbl_i  in  1  run enable; low = no new fetches issued.
REQ-005 redirect_i  in  1  branch/jump taken this cycle.
REQ-006 redirect_pc_i  in  32  redirect target address.
REQ-007 imem_req_o  out  1  instruction-memory request.
REQ-008 imem_addr_o  out  32  request address, word aligned.
REQ-009 imem_gnt_i  in  1  request accepted this cycle.
REQ-010 imem_rvalid_i  in  1  read data valid this cycle.
REQ-011 imem_rdata_i  in  32  read data.
REQ-012 instr_valid_o  out  1  fetched instruction available to decode.
REQ-013 instr_o  out  32  fetched instruction.
REQ-014 instr_pc_o  out  32  address of instr_o.
REQ-015 instr_ready_i  in  1  decode accepts instr_o this cycle.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, HOLD; at most one transaction outstanding.
REQ-017 IDLE: imem_req_o=0; enbl_i=1 -> REQ next cycle.
REQ-018 REQ: imem_req_o=1, imem_addr_o=pc_q; imem_gnt_i=1 -> WAIT and record issued address; enbl_i=0 without grant -> IDLE.
REQ-019 WAIT: imem_rvalid_i=1, no kill -> register rdata into instr_o, issued address into instr_pc_o, pc_q <= issued+4, -> HOLD.
REQ-020 Latency: instr_valid_o SHALL assert the cycle after imem_rvalid_i; gnt-to-valid minimum 2 cycles.
REQ-021 HOLD: instr_valid_o=1, instr_o/instr_pc_o stable; instr_ready_i=1 -> REQ if enbl_i else IDLE; valid deasserts next cycle.
REQ-022 redirect_i SHALL have highest priority in all states: pc_q <= {redirect_pc_i[31:2],2'b00}.
REQ-023 redirect in REQ without grant: next-cycle imem_addr_o = new target; redirect coincident with grant: granted transaction marked kill.
REQ-024 redirect in WAIT: set kill; returning rvalid discarded, no instr_valid_o, -> REQ (IDLE if enbl_i=0), kill cleared.
REQ-025 redirect in HOLD (incl. same cycle as instr_ready_i): held instruction discarded, instr_valid_o=0 next cycle, -> REQ/IDLE per enbl_i.
REQ-026 enbl_i=0 in WAIT or HOLD SHALL NOT abort; transaction completes, then IDLE.
REQ-027 imem_rvalid_i outside WAIT SHALL be ignored.
REQ-028 PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

Reset
REQ-029 rst_ni=0 at a rising edge, in any state: state=IDLE, pc_q=RESET_PC, kill=0, imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=32'h0000_0013 (NOP), instr_pc_o=0.
REQ-030 Response for a transaction granted before reset SHALL be ignored after reset.

Structure
REQ-031 State enum fetch_state_e, NOP constant 32'h0000_0013 and PC_STEP=4 SHALL live in shared package fetch_pkg.
REQ-032 PC register with increment/redirect/alignment SHALL be sub-module fetch_pc_reg; FSM and output registers in fetch_ctrl.

Verification
REQ-033 Reset, enbl_i=1, gnt and rvalid each one cycle after request, ready=1: addresses 0,4,8; instr_pc_o 0,4,8 matching rdata.
REQ-034 Decode stall: ready=0 for 5 cycles in HOLD -> instr_o/instr_pc_o constant, no imem_req_o until ready.
REQ-035 redirect to 32'h0000_0103 during WAIT of PC 8 -> rdata for 8 dropped, next request address 32'h0000_0100.
REQ-036 pc_q=32'hFFFF_FFFC fetched -> next request address 32'h0000_0000.
REQ-037 rst_ni=0 during WAIT, late rvalid after release -> outputs at reset values, first request at RESET_PC, late data never presented.
REQ-038 enbl_i=0 in REQ without grant -> imem_req_o=0 next cycle, IDLE; re-enable resumes at same PC.
